// File: rtl/cnt_wrap_tracker.sv
// Monitors an upstream modulo-N counter: counts wraps into an epoch register, flags
// sequence errors, and queues wrap/error events in a small FIFO for a consumer.
module cnt_wrap_tracker #(
  parameter int N       = 4,
  parameter int EPOCH_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         cnt_in,
  input  logic                 clr_flags,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [EPOCH_W+N:0]   evt_data,
  output logic [EPOCH_W-1:0]   epoch,
  output logic                 err_flag,
  output logic                 drop_flag,
  output logic [1:0]           dbg_state
);

  localparam int EW = 1 + EPOCH_W + N;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N:0]  LAST  = (N+1)'(N - 1);
  localparam logic [N:0]  LIMIT = (N+1)'(N);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_TRACK    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   acq_load, track_chk;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_DISABLED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DISABLED: if (en) state_d = S_ACQUIRE;
      S_ACQUIRE:  state_d = en ? S_TRACK : S_DISABLED;
      S_TRACK:    if (!en) state_d = S_DISABLED;
      default:    state_d = S_DISABLED;
    endcase
  end

  always_comb begin
    acq_load  = (state_q == S_ACQUIRE) && en;
    track_chk = (state_q == S_TRACK) && en;
    dbg_state = state_q;
  end

  // Sequence check; widened by one bit so an out-of-range prev never aliases to 0.
  logic [N-1:0]       prev_q, prev_d;
  logic [N:0]         expected;
  logic               is_wrap, is_err;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  always_comb begin
    expected = ({1'b0, prev_q} == LAST) ? '0 : {1'b0, prev_q} + 1'b1;
    is_wrap  = track_chk && ({1'b0, prev_q} == LAST) && (cnt_in == '0);
    is_err   = track_chk && !is_wrap &&
               (({1'b0, cnt_in} != expected) || ({1'b0, cnt_in} >= LIMIT));
    prev_d   = (acq_load || track_chk) ? cnt_in : prev_q;
    epoch_d  = is_wrap ? epoch_q + 1'b1 : epoch_q;
  end

  // Event FIFO: circular buffer with occupancy count, no empty-bypass.
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, push_ok, drop_evt;
  logic [EW-1:0] push_data;
  logic          err_d, drop_d;

  always_comb begin
    push      = is_wrap || is_err;
    push_data = {is_err, epoch_d, cnt_in};
    pop       = evt_valid && evt_ready;
    push_ok   = push && ((count_q != FULL) || pop);
    drop_evt  = push && !push_ok;
    count_d   = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d  = is_err || (err_flag && !clr_flags);
    drop_d = drop_evt || (drop_flag && !clr_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      epoch_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      epoch_q   <= epoch_d;
      count_q   <= count_d;
      err_flag  <= err_d;
      drop_flag <= drop_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = mem_q[rd_ptr_q];
  assign epoch     = epoch_q;

endmodule
